// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared definitions for the bus arbiter slice.
// Provides the global bus-width define (if not already set elsewhere)
// and the arbiter FSM state encoding.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_TURN  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: requester-side bundle of the shared bus.
//   req      per-requester level request
//   d        packed requester data, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt      one-hot registered grant
//   sel      registered mux select (current/last owner)
//   bus_busy high while any grant is active
//   bus_y    data of the selected lane
// Modports: master = requesters, slave = arbiter.
interface bus_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int SEL_WIDTH  = $clog2(NUM_REQ),
  parameter int DATA_WIDTH = `DATA_WIDTH
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] d;
  logic [NUM_REQ-1:0]            gnt;
  logic [SEL_WIDTH-1:0]          sel;
  logic                          bus_busy;
  logic [DATA_WIDTH-1:0]         bus_y;

  modport master (output req, d, input gnt, sel, bus_busy, bus_y);
  modport slave  (input req, d, output gnt, sel, bus_busy, bus_y);
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// bus_arbiter_rr_pick: combinational round-robin search.
//   req        request vector
//   last_owner index of the most recent owner (searched last)
//   pick       first requesting index after last_owner, wrapping
//   any_req    at least one request is set
module bus_arbiter_rr_pick #(
  parameter int NUM_REQ   = 4,
  parameter int SEL_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [SEL_WIDTH-1:0] last_owner,
  output logic [SEL_WIDTH-1:0] pick,
  output logic                 any_req
);
  logic [SEL_WIDTH-1:0] idx;

  // Walk from the farthest offset to the nearest so the nearest set bit
  // wins. NUM_REQ is a power of two, so SEL_WIDTH arithmetic wraps mod
  // NUM_REQ, and offset NUM_REQ lands back on last_owner itself.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    pick = '0;
    idx  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = last_owner + SEL_WIDTH'(i);
      if (req[idx]) pick = idx;
    end
  end

  assign any_req = |req;
endmodule

// File: rtl/mux_array.sv
// mux_array: bus-decode multiplexer selecting one DATA_WIDTH lane out of
// MUX_DATA_WIDTH packed lanes.
//   din  packed lanes, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   sel  lane index
//   y    selected lane (combinational)
module mux_array #(
  parameter int MUX_DATA_WIDTH = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int SEL_W          = $clog2(MUX_DATA_WIDTH)
) (
  input  logic [MUX_DATA_WIDTH*DATA_WIDTH-1:0] din,
  input  logic [SEL_W-1:0]                     sel,
  output logic [DATA_WIDTH-1:0]                y
);
  assign y = din[sel*DATA_WIDTH +: DATA_WIDTH];
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of a shared data bus with a one-cycle
// dead turnaround between owners and optional hold-time preemption.
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    slave side of bus_arbiter_if (req/d in; gnt/sel/bus_busy/bus_y out)
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int SEL_WIDTH  = $clog2(NUM_REQ),
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int MAX_HOLD   = 8
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);
  generate
    if (NUM_REQ != 2 && NUM_REQ != 4) begin : g_bad_num_req
      $error("bus_arbiter: NUM_REQ must be 2 or 4");
    end
  endgenerate

  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  arb_state_e           state;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [SEL_WIDTH-1:0] sel_q;
  logic [SEL_WIDTH-1:0] last_owner;
  logic [HOLD_W-1:0]    hold_cnt;
  logic                 busy_q;

  logic [SEL_WIDTH-1:0] pick;
  logic                 any_req;
  logic                 others_waiting;
  logic [DATA_WIDTH-1:0] mux_y;

  bus_arbiter_rr_pick #(
    .NUM_REQ   (NUM_REQ),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_pick (
    .req        (bus.req),
    .last_owner (last_owner),
    .pick       (pick),
    .any_req    (any_req)
  );

  // In GRANT gnt_q is one-hot on the owner, so this masks the owner out.
  assign others_waiting = |(bus.req & ~gnt_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB_IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      busy_q     <= 1'b0;
      hold_cnt   <= '0;
      last_owner <= SEL_WIDTH'(NUM_REQ - 1);
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      case (state)
        ARB_IDLE, ARB_TURN: begin
          if (any_req) begin
            state      <= ARB_GRANT;
            gnt_q      <= NUM_REQ'(1) << pick;
            sel_q      <= pick;
            last_owner <= pick;
            busy_q     <= 1'b1;
            hold_cnt   <= '0;
          end else begin
            state  <= ARB_IDLE;
            gnt_q  <= '0;
            busy_q <= 1'b0;
          end
        end
        ARB_GRANT: begin
          // Owner release takes precedence over preemption; both give
          // the same TURN result.
          if (!bus.req[sel_q] ||
              (MAX_HOLD != 0 && hold_cnt == HOLD_LAST && others_waiting)) begin
            state  <= ARB_TURN;
            gnt_q  <= '0;
            busy_q <= 1'b0;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state  <= ARB_IDLE;
          gnt_q  <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  mux_array #(
    .MUX_DATA_WIDTH (NUM_REQ),
    .DATA_WIDTH     (DATA_WIDTH),
    .SEL_W          (SEL_WIDTH)
  ) u_mux (
    .din (bus.d),
    .sel (sel_q),
    .y   (mux_y)
  );

  assign bus.gnt      = gnt_q;
  assign bus.sel      = sel_q;
  assign bus.bus_busy = busy_q;
  assign bus.bus_y    = mux_y;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed self-checking bench for bus_arbiter.
// dut_a uses MAX_HOLD=8, dut_b uses MAX_HOLD=0; both see identical inputs.
module tb_bus_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;

  logic clk;
  logic clk_en;
  logic reset;
  int   checks;
  int   failures;

  bus_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus_a ();
  bus_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus_b ();

  bus_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_HOLD(8)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  bus_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_HOLD(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = clk_en ? ~clk : clk;
  end

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic [7:0] y;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input logic [3:0] r);
    bus_a.req = r;
    bus_b.req = r;
  endtask

  // Advance one rising edge and settle away from it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_req(4'b0000);
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  vec_t vecs[15];

  initial begin
    checks   = 0;
    failures = 0;
    clk_en   = 1'b0;
    reset    = 1'b0;
    set_req(4'b0000);
    bus_a.d = {8'h3C, 8'hA5, 8'h5A, 8'h11};
    bus_b.d = {8'h3C, 8'hA5, 8'h5A, 8'h11};

    // Reset with the clock stopped.
    #3 reset = 1'b1;
    #1;
    check("rst_gnt",  32'(bus_a.gnt), 32'h0);
    check("rst_sel",  32'(bus_a.sel), 32'h0);
    check("rst_busy", 32'(bus_a.bus_busy), 32'h0);
    #5 reset = 1'b0;
    clk_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("idle_gnt", 32'(bus_a.gnt), 32'h0);
    end

    // One vector per edge, starting from IDLE with last_owner=3.
    vecs[0]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 8'hA5};
    vecs[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 8'hA5};
    vecs[2]  = '{4'b0000, 4'b0000, 2'd2, 1'b0, 8'h00};
    vecs[3]  = '{4'b0000, 4'b0000, 2'd2, 1'b0, 8'h00};
    vecs[4]  = '{4'b0011, 4'b0001, 2'd0, 1'b1, 8'h11};
    vecs[5]  = '{4'b0011, 4'b0001, 2'd0, 1'b1, 8'h11};
    vecs[6]  = '{4'b0010, 4'b0000, 2'd0, 1'b0, 8'h00};
    vecs[7]  = '{4'b0010, 4'b0010, 2'd1, 1'b1, 8'h5A};
    vecs[8]  = '{4'b1001, 4'b0000, 2'd1, 1'b0, 8'h00};
    vecs[9]  = '{4'b1001, 4'b1000, 2'd3, 1'b1, 8'h3C};
    vecs[10] = '{4'b1001, 4'b1000, 2'd3, 1'b1, 8'h3C};
    vecs[11] = '{4'b0001, 4'b0000, 2'd3, 1'b0, 8'h00};
    vecs[12] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 8'h11};
    vecs[13] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 8'h00};
    vecs[14] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 8'h00};

    for (int i = 0; i < 15; i++) begin
      set_req(vecs[i].req);
      cycle();
      check($sformatf("vec%0d_gnt", i),  32'(bus_a.gnt), 32'(vecs[i].gnt));
      check($sformatf("vec%0d_sel", i),  32'(bus_a.sel), 32'(vecs[i].sel));
      check($sformatf("vec%0d_busy", i), 32'(bus_a.bus_busy), 32'(vecs[i].busy));
      if (vecs[i].busy)
        check($sformatf("vec%0d_bus_y", i), 32'(bus_a.bus_y), 32'(vecs[i].y));
    end

    // Round robin: all requesting, each owner drops after two grant cycles.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (k % 4);
      set_req(4'b1111);
      cycle();
      check($sformatf("rr%0d_gnt_first", k), 32'(bus_a.gnt), 32'(exp_g));
      cycle();
      check($sformatf("rr%0d_gnt_second", k), 32'(bus_a.gnt), 32'(exp_g));
      set_req(4'b1111 & ~exp_g);
      cycle();
      check($sformatf("rr%0d_turn", k), 32'(bus_a.gnt), 32'h0);
    end

    // Preemption after 8 grant cycles; dut_b never preempts.
    do_reset();
    set_req(4'b0001);
    for (int e = 1; e <= 20; e++) begin
      cycle();
      if (e == 3) set_req(4'b0011);
      if (e <= 8)
        check($sformatf("pre_hold%0d", e), 32'(bus_a.gnt), 32'h1);
      else if (e == 9)
        check("pre_turn", 32'(bus_a.gnt), 32'h0);
      else if (e == 10)
        check("pre_next", 32'(bus_a.gnt), 32'h2);
      check($sformatf("nopre_hold%0d", e), 32'(bus_b.gnt), 32'h1);
    end

    // Sole requester keeps the bus with no turnaround.
    do_reset();
    set_req(4'b1000);
    for (int e = 1; e <= 20; e++) begin
      cycle();
      check($sformatf("solo%0d_gnt", e), 32'(bus_a.gnt), 32'h8);
    end

    // Asynchronous reset between edges while requester 1 owns the bus.
    do_reset();
    set_req(4'b0010);
    cycle();
    check("async_pre_gnt", 32'(bus_a.gnt), 32'h2);
    #2 reset = 1'b1;
    #1;
    check("async_gnt", 32'(bus_a.gnt), 32'h0);
    check("async_busy", 32'(bus_a.bus_busy), 32'h0);
    check("async_sel", 32'(bus_a.sel), 32'h0);
    #1 reset = 1'b0;
    set_req(4'b1010);
    cycle();
    check("async_regrant", 32'(bus_a.gnt), 32'h2);
    check("async_regrant_sel", 32'(bus_a.sel), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
